// File: rtl/fechadura_if.sv
// fechadura_if: keypad-to-controller bus of the electronic lock.
// change_req is present only when PWD_CHANGE_EN is defined.
interface fechadura_if #(
    parameter int N_DIGITS = 4
);
    logic                          digit_valid;
    logic [3:0]                    digit;
    logic                          confirm;
    logic                          clear;
`ifdef PWD_CHANGE_EN
    logic                          change_req;
`endif
    logic                          unlocked;
    logic                          error;
    logic                          blocked;
    logic [$clog2(N_DIGITS+1)-1:0] digits_entered;
`ifdef PWD_CHANGE_EN
    modport master (output digit_valid, digit, confirm, clear, change_req,
                    input unlocked, error, blocked, digits_entered);
    modport slave (input digit_valid, digit, confirm, clear, change_req,
                   output unlocked, error, blocked, digits_entered);
`else
    modport master (output digit_valid, digit, confirm, clear,
                    input unlocked, error, blocked, digits_entered);
    modport slave (input digit_valid, digit, confirm, clear,
                   output unlocked, error, blocked, digits_entered);
`endif
endinterface

// File: rtl/fechadura_ctrl.sv
// fechadura_ctrl: password controller of the electronic lock (entry, check, open/error/lockout timing).
// Optional PWD_CHANGE_EN: change_req in OPEN enters NEW_PWD to replace the stored password.
module fechadura_ctrl #(
    parameter int                    N_DIGITS      = 4,
    parameter logic [4*N_DIGITS-1:0] PASSWORD      = 16'h1234,
    parameter int                    MAX_TRIES     = 3,
    parameter int                    UNLOCK_CYCLES = 50000,
    parameter int                    ERR_CYCLES    = 5000,
    parameter int                    LOCK_CYCLES   = 500000
) (
    input logic        clk,
    input logic        rst,
    fechadura_if.slave bus
);
    localparam int BW    = 4 * N_DIGITS;
    localparam int CW    = $clog2(N_DIGITS + 1);
    localparam int RW    = $clog2(MAX_TRIES + 1);
    localparam int T_MAX = UNLOCK_CYCLES > ERR_CYCLES
                         ? (UNLOCK_CYCLES > LOCK_CYCLES ? UNLOCK_CYCLES : LOCK_CYCLES)
                         : (ERR_CYCLES > LOCK_CYCLES ? ERR_CYCLES : LOCK_CYCLES);
    localparam int TW    = $clog2(T_MAX + 1);

    typedef enum logic [2:0] {IDLE, ENTRY, CHECK, OPEN, ERROR, BLOCKED, NEW_PWD} state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   buf_q, buf_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   tries_q, tries_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [BW-1:0]   pwd_q;
    logic            full, dig_ok, expired;

    assign full    = cnt_q == CW'(N_DIGITS);
    assign dig_ok  = bus.digit_valid && bus.digit <= 4'd9;
    assign expired = timer_q == TW'(1);

`ifdef PWD_CHANGE_EN
    logic [BW-1:0] pwd_d;
    always_ff @(posedge clk or posedge rst)
        if (rst) pwd_q <= PASSWORD;
        else     pwd_q <= pwd_d;
`else
    assign pwd_q = PASSWORD;
`endif

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        tries_d = tries_q;
        timer_d = expired ? timer_q : timer_q - TW'(1);
`ifdef PWD_CHANGE_EN
        pwd_d   = pwd_q;
`endif
        case (state_q)
            IDLE, ENTRY, NEW_PWD: begin
                if (bus.confirm) begin
`ifdef PWD_CHANGE_EN
                    if (state_q == NEW_PWD) begin
                        buf_d   = '0;
                        cnt_d   = '0;
                        timer_d = TW'(ERR_CYCLES);
                        state_d = full ? IDLE : ERROR;
                        pwd_d   = full ? buf_q : pwd_q;
                    end else
`endif
                    state_d = CHECK;
                end else if (bus.clear) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = state_q == NEW_PWD ? NEW_PWD : IDLE;
                end else if (dig_ok) begin
                    buf_d   = full ? buf_q : (buf_q << 4) | BW'(bus.digit);
                    cnt_d   = full ? cnt_q : cnt_q + CW'(1);
                    state_d = state_q == NEW_PWD ? NEW_PWD : ENTRY;
                end
            end
            CHECK: begin
                buf_d = '0;
                cnt_d = '0;
                if (full && buf_q == pwd_q) begin
                    tries_d = '0;
                    timer_d = TW'(UNLOCK_CYCLES);
                    state_d = OPEN;
                end else begin
                    tries_d = tries_q + RW'(1);
                    // the failure that reaches MAX_TRIES goes straight to lockout
                    state_d = tries_d == RW'(MAX_TRIES) ? BLOCKED : ERROR;
                    timer_d = tries_d == RW'(MAX_TRIES) ? TW'(LOCK_CYCLES) : TW'(ERR_CYCLES);
                end
            end
            OPEN: begin
`ifdef PWD_CHANGE_EN
                if (bus.change_req) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = NEW_PWD;
                end else
`endif
                state_d = expired ? IDLE : OPEN;
            end
            ERROR:   state_d = expired ? IDLE : ERROR;
            BLOCKED: begin
                state_d = expired ? IDLE : BLOCKED;
                tries_d = expired ? '0 : tries_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
            tries_q <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            tries_q <= tries_d;
            timer_q <= timer_d;
        end

    assign bus.unlocked       = state_q == OPEN || state_q == NEW_PWD;
    assign bus.error          = state_q == ERROR;
    assign bus.blocked        = state_q == BLOCKED;
    assign bus.digits_entered = cnt_q;
endmodule

// File: tb/tb_fechadura_ctrl.sv
// tb_fechadura_ctrl: directed-vector bench for fechadura_ctrl with short status timings.
// Exercises the PWD_CHANGE_EN path as well when that macro is defined.
module tb_fechadura_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fechadura_if #(.N_DIGITS(4)) bus ();

    fechadura_ctrl #(
        .N_DIGITS(4), .PASSWORD(16'h1234), .MAX_TRIES(3),
        .UNLOCK_CYCLES(20), .ERR_CYCLES(5), .LOCK_CYCLES(40)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int status();
        return int'({bus.blocked, bus.error, bus.unlocked});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] d);
        bus.digit = d;
        bus.digit_valid = 1'b1;
        step();
        bus.digit_valid = 1'b0;
    endtask

    task automatic code(input logic [15:0] c);
        for (int i = 3; i >= 0; i--) key(c[i*4 +: 4]);
    endtask

    task automatic conf();
        bus.confirm = 1'b1;
        step();
        bus.confirm = 1'b0;
    endtask

    // which: 0 unlocked, 1 error, 2 blocked; counts remaining high cycles from now
    task automatic hold(input string tag, input int which, input int len);
        int n = 0;
        bit bad = 1'b0;
        while (n < len + 10 && ((status() >> which) & 1) == 1) begin
            if (status() != (1 << which)) bad = 1'b1;
            n++;
            step();
        end
        check({tag, " len"}, n, len);
        check({tag, " excl"}, int'(bad), 0);
        check({tag, " after"}, status(), 0);
    endtask

    task automatic attempt(input string tag, input logic [15:0] c, input int which, input int len);
        code(c);
        conf();
        check({tag, " check"}, status(), 0);
        step();
        hold(tag, which, len);
    endtask

    initial begin
        bus.digit_valid = 1'b0;
        bus.digit = 4'd0;
        bus.confirm = 1'b0;
        bus.clear = 1'b0;
`ifdef PWD_CHANGE_EN
        bus.change_req = 1'b0;
`endif
        #2;
        check("rst status", status(), 0);
        check("rst digits", int'(bus.digits_entered), 0);
        step();
        rst = 1'b0;
        step();

        code(16'h1234);
        check("full count", int'(bus.digits_entered), 4);
        conf();
        check("good check", status(), 0);
        step();
        hold("good", 0, 20);

        attempt("bad1", 16'h1235, 1, 5);
        attempt("bad2", 16'h1235, 1, 5);
        code(16'h1235);
        conf();
        step();
        check("blk entry", status(), 4);
        code(16'h1234);
        check("blk digits", int'(bus.digits_entered), 0);
        conf();
        hold("blk", 2, 35);
        attempt("post blk", 16'h1234, 0, 20);

        code(16'h1234);
        key(4'd9);
        check("sat count", int'(bus.digits_entered), 4);
        conf();
        step();
        hold("sat", 0, 20);
        key(4'd1);
        key(4'd2);
        conf();
        step();
        hold("short", 1, 5);
        key(4'hB);
        check("bcd ign cnt", int'(bus.digits_entered), 0);
        check("bcd ign st", status(), 0);

        key(4'd1);
        key(4'd2);
        key(4'd3);
        bus.digit = 4'd4;
        bus.digit_valid = 1'b1;
        bus.confirm = 1'b1;
        step();
        bus.digit_valid = 1'b0;
        bus.confirm = 1'b0;
        step();
        hold("conf prio", 1, 5);
        key(4'd1);
        key(4'd2);
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        check("clear cnt", int'(bus.digits_entered), 0);
        check("clear st", status(), 0);
        key(4'd1);
        key(4'd2);
        key(4'd3);
        bus.digit = 4'd4;
        bus.digit_valid = 1'b1;
        bus.clear = 1'b1;
        step();
        bus.digit_valid = 1'b0;
        bus.clear = 1'b0;
        check("clr prio cnt", int'(bus.digits_entered), 0);
        attempt("after clr", 16'h1234, 0, 20);

        key(4'd1);
        key(4'd2);
        check("mid entry cnt", int'(bus.digits_entered), 2);
        rst = 1'b1;
        #2;
        check("arst entry cnt", int'(bus.digits_entered), 0);
        check("arst entry st", status(), 0);
        #1 rst = 1'b0;
        step();
        attempt("rb1", 16'h1111, 1, 5);
        attempt("rb2", 16'h1111, 1, 5);
        code(16'h1111);
        conf();
        step();
        step();
        check("rb blk", status(), 4);
        rst = 1'b1;
        #2;
        check("arst blk st", status(), 0);
        check("arst blk cnt", int'(bus.digits_entered), 0);
        #1 rst = 1'b0;
        step();
        attempt("after arst", 16'h1234, 0, 20);

`ifdef PWD_CHANGE_EN
        code(16'h1234);
        conf();
        step();
        check("chg open", status(), 1);
        bus.change_req = 1'b1;
        step();
        bus.change_req = 1'b0;
        check("newpwd st", status(), 1);
        check("newpwd cnt", int'(bus.digits_entered), 0);
        code(16'h9876);
        check("newpwd full", int'(bus.digits_entered), 4);
        conf();
        check("newpwd done", status(), 0);
        attempt("new ok", 16'h9876, 0, 20);
        attempt("old bad", 16'h1234, 1, 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        attempt("reverted", 16'h1234, 0, 20);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
